// File: rtl/wb_uart_rx.sv
// Wishbone-slave UART receiver: 16x-oversampled 8N1 deframer feeding a receive FIFO,
// with RXDATA/STATUS/BAUDDIV/IRQ_EN registers and a registered level interrupt.
module wb_uart_rx #(
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned DEFAULT_DIV = 53
) (
  input  logic        wb_clk,
  input  logic        wb_rst_n,
  input  logic [1:0]  wb_adr,
  input  logic [31:0] wb_dat,
  input  logic [3:0]  wb_sel,
  input  logic        wb_we,
  input  logic        wb_cyc,
  input  logic        wb_stb,
  output logic [31:0] wb_rdt,
  output logic        wb_ack,
  input  logic        rx_pad_i,
  output logic        o_irq
);
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned DIV_W = 16;

  localparam logic [1:0] ADR_RXDATA  = 2'd0;
  localparam logic [1:0] ADR_STATUS  = 2'd1;
  localparam logic [1:0] ADR_BAUDDIV = 2'd2;
  localparam logic [1:0] ADR_IRQEN   = 2'd3;

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_e;

  state_e             state_q, state_d;
  logic [3:0]         tick_cnt_q, tick_cnt_d;
  logic [2:0]         bit_cnt_q, bit_cnt_d;
  logic [7:0]         shift_q, shift_d;
  logic [1:0]         sync_q;
  logic               rx_prev_q;
  logic [DIV_W-1:0]   baud_cnt_q, baud_cnt_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [1:0]         en_q, en_d;
  logic               ovr_q, ovr_d, fe_q, fe_d;
  logic               ack_q, irq_q, irq_d;
  logic [31:0]        rdt_q, rdt_d;
  logic [7:0]         mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic rx_s, fall_c, tick_c, push_c, fe_set_c;
  logic req_c, rd_c, wr_c, pop_c, do_push_c, ovr_set_c, full_c, not_empty_c;
  logic unused_bits;

  assign unused_bits = ^{wb_dat[31:16], wb_sel[3:2]};

  assign rx_s        = sync_q[1];
  assign fall_c      = rx_prev_q & ~rx_s;
  assign tick_c      = (baud_cnt_q == '0);
  assign full_c      = (count_q == CNT_W'(FIFO_DEPTH));
  assign not_empty_c = (count_q != '0);

  assign req_c     = wb_cyc & wb_stb & ~ack_q;
  assign rd_c      = req_c & ~wb_we;
  assign wr_c      = req_c & wb_we;
  assign pop_c     = rd_c & (wb_adr == ADR_RXDATA) & not_empty_c;
  assign do_push_c = push_c & (~full_c | pop_c);
  assign ovr_set_c = push_c & full_c & ~pop_c;

  assign wb_rdt = rdt_q;
  assign wb_ack = ack_q;
  assign o_irq  = irq_q;

  // Baud tick: reloads at zero, restarts on a start edge so sampling is phase-locked to it.
  always_comb begin
    baud_cnt_d = baud_cnt_q - DIV_W'(1);
    if (((state_q == ST_IDLE) && fall_c) || tick_c) begin
      baud_cnt_d = div_q;
    end
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q    <= ST_IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
    end
  end

  // Deframer: mid-start check at tick 7, then one sample every 16 ticks.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    push_c     = 1'b0;
    fe_set_c   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fall_c) begin
          state_d    = ST_START;
          tick_cnt_d = '0;
        end
      end
      ST_START: begin
        if (tick_c) begin
          if (tick_cnt_q == 4'd7) begin
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            state_d    = rx_s ? ST_IDLE : ST_DATA;
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
      end
      ST_DATA: begin
        if (tick_c) begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (tick_cnt_q == 4'd15) begin
            shift_d   = {rx_s, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_d = ST_STOP;
            end
          end
        end
      end
      ST_STOP: begin
        if (tick_c) begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (tick_cnt_q == 4'd15) begin
            push_c   = rx_s;
            fe_set_c = ~rx_s;
            state_d  = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FIFO bookkeeping; a pop frees the slot for a same-cycle push.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push_c) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (do_push_c && !pop_c) begin
      count_d = count_q + CNT_W'(1);
    end else if (!do_push_c && pop_c) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Register file, read mux and interrupt.
  always_comb begin
    rdt_d = '0;
    div_d = div_q;
    en_d  = en_q;
    ovr_d = ovr_q | ovr_set_c;
    fe_d  = fe_q | fe_set_c;
    if (wr_c) begin
      case (wb_adr)
        ADR_STATUS: begin
          if (wb_dat[2] && !ovr_set_c) ovr_d = 1'b0;
          if (wb_dat[3] && !fe_set_c)  fe_d  = 1'b0;
        end
        ADR_BAUDDIV: begin
          if (wb_sel[0]) div_d[7:0]  = wb_dat[7:0];
          if (wb_sel[1]) div_d[15:8] = wb_dat[15:8];
        end
        ADR_IRQEN: en_d = wb_dat[1:0];
        default: ;
      endcase
    end
    if (rd_c) begin
      case (wb_adr)
        ADR_RXDATA:  rdt_d = not_empty_c ? {24'd0, mem_q[rd_ptr_q]} : 32'd0;
        ADR_STATUS:  rdt_d = {16'd0, 8'(count_q), 4'd0, fe_q, ovr_q, full_c, not_empty_c};
        ADR_BAUDDIV: rdt_d = {16'd0, div_q};
        default:     rdt_d = {30'd0, en_q};
      endcase
    end
    irq_d = (en_q[0] & not_empty_c) | (en_q[1] & (ovr_q | fe_q));
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      sync_q     <= 2'b11;
      rx_prev_q  <= 1'b1;
      baud_cnt_q <= DIV_W'(DEFAULT_DIV);
      div_q      <= DIV_W'(DEFAULT_DIV);
      en_q       <= '0;
      ovr_q      <= 1'b0;
      fe_q       <= 1'b0;
      ack_q      <= 1'b0;
      irq_q      <= 1'b0;
      rdt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      sync_q     <= {sync_q[0], rx_pad_i};
      rx_prev_q  <= rx_s;
      baud_cnt_q <= baud_cnt_d;
      div_q      <= div_d;
      en_q       <= en_d;
      ovr_q      <= ovr_d;
      fe_q       <= fe_d;
      ack_q      <= req_c;
      irq_q      <= irq_d;
      rdt_q      <= rdt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset: only entries covered by count are ever read.
  always_ff @(posedge wb_clk) begin
    if (do_push_c) begin
      mem_q[wr_ptr_q] <= shift_q;
    end
  end

endmodule
